// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial output port: snoops core writes into a character FIFO,
// serializes them on tx_o and exposes a one-cycle-latency status word.
module uart_tx_port #(
   parameter int WORD_SIZE      = 20,
   parameter int CLOCKS_PER_BIT = 16,
   parameter int FIFO_DEPTH     = 8,
   parameter logic [WORD_SIZE-1:0] DATA_ADDR   = WORD_SIZE'('h3fff),
   parameter logic [WORD_SIZE-1:0] STATUS_ADDR = WORD_SIZE'('h3ffe)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] addr_i,
   input  logic [WORD_SIZE-1:0] value_i,
   input  logic                 write_i,
   output logic [WORD_SIZE-1:0] status_o,
   output logic                 status_hit_o,
   output logic                 tx_o,
   output logic                 busy_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int BIT_W = $clog2(CLOCKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

   logic [7:0]           mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 overflow_q, overflow_d;
   txState_t             state_q, state_d;
   logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
   logic [2:0]           bitIdx_q, bitIdx_d;
   logic [7:0]           shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 busy_q;
   logic [WORD_SIZE-1:0] status_q;
   logic                 statusHit_q;

   logic full, empty, pushReq, pushOk, clearReq, pop, lastTick, statusSel;
   logic [WORD_SIZE-1:0] statusWord;

   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign pushReq   = write_i && (addr_i == DATA_ADDR);
   assign pushOk    = pushReq && !full;
   assign statusSel = (addr_i == STATUS_ADDR);
   assign clearReq  = write_i && statusSel;
   assign lastTick  = (bitCnt_q == BIT_W'(CLOCKS_PER_BIT - 1));

   assign statusWord = WORD_SIZE'({4'(count_q), (state_q != IDLE), overflow_q, empty, full});

   // Pushes use the pre-edge count, so a same-edge pop never makes room for them.
   always_comb begin
      count_d = count_q;
      if (pushOk && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !pushOk) begin
         count_d = count_q - CNT_W'(1);
      end
      overflow_d = overflow_q;
      if (pushReq && full) begin
         overflow_d = 1'b1;
      end else if (clearReq) begin
         overflow_d = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      pop      = 1'b0;
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop      = 1'b1;
               shift_d  = mem_q[rdPtr_q];
               bitCnt_d = '0;
               tx_d     = 1'b0;
               state_d  = START;
            end
         end
         START: begin
            if (lastTick) begin
               bitCnt_d = '0;
               bitIdx_d = 3'd0;
               tx_d     = shift_q[0];
               state_d  = DATA;
            end else begin
               bitCnt_d = bitCnt_q + BIT_W'(1);
            end
         end
         DATA: begin
            if (lastTick) begin
               bitCnt_d = '0;
               if (bitIdx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 3'd1;
                  shift_d  = shift_q >> 1;
                  tx_d     = shift_q[1];
               end
            end else begin
               bitCnt_d = bitCnt_q + BIT_W'(1);
            end
         end
         STOP: begin
            if (lastTick) begin
               bitCnt_d = '0;
               // Chain straight into the next start bit so queued bytes leave no idle gap.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rdPtr_q];
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               bitCnt_d = bitCnt_q + BIT_W'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (pushOk) begin
         mem_q[wrPtr_q] <= value_i[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         state_q     <= IDLE;
         bitCnt_q    <= '0;
         bitIdx_q    <= 3'd0;
         shift_q     <= 8'd0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         status_q    <= '0;
         statusHit_q <= 1'b0;
      end else begin
         if (pushOk) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (pop)    rdPtr_q <= rdPtr_q + PTR_W'(1);
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         state_q     <= state_d;
         bitCnt_q    <= bitCnt_d;
         bitIdx_q    <= bitIdx_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         busy_q      <= (state_d != IDLE) || (count_d != '0);
         statusHit_q <= statusSel;
         if (statusSel) status_q <= statusWord;
      end
   end

   assign tx_o         = tx_q;
   assign busy_o       = busy_q;
   assign status_o     = status_q;
   assign status_hit_o = statusHit_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: a cycle-level transaction model predicts
// the serial line, busy flag and status reads, driven by directed and random writes.
module tb_uart_tx_port;

   localparam int CPB        = 4;
   localparam int DEPTH      = 8;
   localparam logic [19:0] DATA_A   = 20'h3fff;
   localparam logic [19:0] STATUS_A = 20'h3ffe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] addr = '0, value = '0;
   logic        write = 1'b0;
   logic [19:0] status;
   logic        hit, tx, busy;

   logic [19:0] addr2 = '0, value2 = '0;
   logic        write2 = 1'b0;
   logic [19:0] status2;
   logic        hit2, tx2, busy2;

   int testCount = 0;
   int failCount = 0;
   bit modelOn = 1'b0;

   uart_tx_port #(.WORD_SIZE(20), .CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
                  .DATA_ADDR(DATA_A), .STATUS_ADDR(STATUS_A)) dut (
      .clk(clk), .reset(reset), .addr_i(addr), .value_i(value), .write_i(write),
      .status_o(status), .status_hit_o(hit), .tx_o(tx), .busy_o(busy));

   // Both addresses alias so one write can push into a full FIFO and clear overflow together.
   uart_tx_port #(.WORD_SIZE(20), .CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(2),
                  .DATA_ADDR(DATA_A), .STATUS_ADDR(DATA_A)) dut2 (
      .clk(clk), .reset(reset), .addr_i(addr2), .value_i(value2), .write_i(write2),
      .status_o(status2), .status_hit_o(hit2), .tx_o(tx2), .busy_o(busy2));

   always #5 clk = ~clk;

   logic [7:0]  q[$];
   logic [7:0]  curByte = 8'd0;
   int          edgeN = 0, frameStart = 0;
   bit          frameActive = 1'b0, mOvf = 1'b0;
   logic        expTx = 1'b1, expBusy = 1'b0, expHit = 1'b0;
   logic [19:0] expStatus = '0;

   // Frame-level model: a frame lasts 10*CPB edges; the next byte starts at its last edge.
   always @(posedge clk) begin : model
      int  preCnt, k;
      bit  frameEnd;
      preCnt   = q.size();
      frameEnd = frameActive && (edgeN == frameStart + 10 * CPB);
      if (reset) begin
         q.delete();
         frameActive = 1'b0;
         mOvf        = 1'b0;
         expHit      = 1'b0;
         expStatus   = '0;
      end else begin
         expHit = (addr == STATUS_A);
         if (expHit) begin
            expStatus = 20'(preCnt * 16 + (frameActive ? 8 : 0) + (mOvf ? 4 : 0)
                           + (preCnt == 0 ? 2 : 0) + (preCnt == DEPTH ? 1 : 0));
         end
         if ((!frameActive || frameEnd) && preCnt > 0) begin
            curByte     = q.pop_front();
            frameStart  = edgeN;
            frameActive = 1'b1;
         end else if (frameEnd) begin
            frameActive = 1'b0;
         end
         if (write && addr == DATA_A) begin
            if (preCnt < DEPTH) q.push_back(value[7:0]);
            else mOvf = 1'b1;
         end else if (write && addr == STATUS_A) begin
            mOvf = 1'b0;
         end
      end
      if (frameActive) begin
         k = (edgeN - frameStart) / CPB;
         if (k == 0) expTx = 1'b0;
         else if (k <= 8) expTx = curByte[k-1];
         else expTx = 1'b1;
      end else begin
         expTx = 1'b1;
      end
      expBusy = frameActive || (q.size() != 0);
      edgeN++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (modelOn) begin
         checkOutput("tx", 32'(tx), 32'(expTx));
         checkOutput("busy", 32'(busy), 32'(expBusy));
         checkOutput("hit", 32'(hit), 32'(expHit));
         checkOutput("status", 32'(status), 32'(expStatus));
      end
   end

   // One bus cycle: inputs settle just after the falling edge, sampled at the next rising edge.
   task automatic applyStimulus(input logic [19:0] a, input logic [19:0] v, input logic w);
      @(negedge clk);
      #1;
      reset = 1'b0;
      addr  = a;
      value = v;
      write = w;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(20'h0, 20'h0, 1'b0);
   endtask

   task automatic pulseReset();
      @(negedge clk);
      #1;
      reset = 1'b1;
      addr  = '0;
      write = 1'b0;
   endtask

   task automatic stepDut2(input logic [19:0] a, input logic [19:0] v, input logic w);
      @(negedge clk);
      #1;
      addr2  = a;
      value2 = v;
      write2 = w;
   endtask

   logic [9:0] frame41;
   int         sent;

   initial begin
      repeat (3) @(negedge clk);
      modelOn = 1'b1;
      checkOutput("rst_tx", 32'(tx), 1);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_status", 32'(status), 0);
      checkOutput("rst_hit", 32'(hit), 0);

      // Status latency on an idle port.
      applyStimulus(STATUS_A, 20'h0, 1'b0);
      applyStimulus(20'h0, 20'h0, 1'b0);
      checkOutput("lat_hit1", 32'(hit), 1);
      checkOutput("lat_status", 32'(status), 'h002);
      applyStimulus(20'h0, 20'h0, 1'b0);
      checkOutput("lat_hit0", 32'(hit), 0);

      // Set wins over clear when both land on the same edge.
      for (int i = 0; i < 4; i++) stepDut2(DATA_A, 20'(8'h30 + i), 1'b1);
      stepDut2(DATA_A, 20'h0, 1'b0);
      checkOutput("setwin_pre", 32'(status2), 'h029);
      stepDut2(20'h0, 20'h0, 1'b0);
      checkOutput("setwin_hit", 32'(hit2), 1);
      checkOutput("setwin_status", 32'(status2), 'h02D);
      idle(120);

      // Single byte: start bit, LSB-first data, stop bit sampled at bit centres.
      frame41 = 10'b1_0100_0001_0;
      applyStimulus(DATA_A, 20'h41, 1'b1);
      for (int j = 1; j <= 45; j++) begin
         applyStimulus(20'h0, 20'h0, 1'b0);
         if (j == 2) checkOutput("s_start_edge", 32'(tx), 0);
         if (j >= 2 + CPB / 2 && (j - 2 - CPB / 2) % CPB == 0 && (j - 2 - CPB / 2) / CPB < 10)
            checkOutput("s_bit", 32'(tx), 32'(frame41[(j - 2 - CPB / 2) / CPB]));
         if (j == 41) checkOutput("s_busy_end", 32'(busy), 1);
         if (j == 42) checkOutput("s_busy_drop", 32'(busy), 0);
      end

      // Back-to-back frames with no idle gap.
      applyStimulus(DATA_A, 20'h55, 1'b1);
      applyStimulus(DATA_A, 20'hAA, 1'b1);
      for (int k = 1; k <= 90; k++) begin
         applyStimulus(20'h0, 20'h0, 1'b0);
         if (k == 40) checkOutput("b2b_stop", 32'(tx), 1);
         if (k == 41) checkOutput("b2b_start2", 32'(tx), 0);
         if (k == 81) checkOutput("b2b_busy_drop", 32'(busy), 0);
      end

      // Overflow: ten writes while the first frame is in flight.
      for (int i = 0; i < 10; i++) applyStimulus(DATA_A, 20'(8'hC0 + i), 1'b1);
      applyStimulus(STATUS_A, 20'h0, 1'b0);
      applyStimulus(20'h0, 20'h0, 1'b0);
      checkOutput("ovf_hit", 32'(hit), 1);
      checkOutput("ovf_status", 32'(status), 'h08D);
      applyStimulus(STATUS_A, 20'h0, 1'b1);
      applyStimulus(STATUS_A, 20'h0, 1'b0);
      applyStimulus(20'h0, 20'h0, 1'b0);
      checkOutput("ovf_cleared", 32'(status), 'h089);
      idle(420);
      checkOutput("ovf_drained", 32'(busy), 0);

      // Reset during data bit 3 with two bytes queued.
      applyStimulus(DATA_A, 20'h5A, 1'b1);
      applyStimulus(DATA_A, 20'h11, 1'b1);
      applyStimulus(DATA_A, 20'h22, 1'b1);
      idle(17);
      pulseReset();
      applyStimulus(20'h0, 20'h0, 1'b0);
      checkOutput("rmid_tx", 32'(tx), 1);
      checkOutput("rmid_busy", 32'(busy), 0);
      applyStimulus(STATUS_A, 20'h0, 1'b0);
      applyStimulus(20'h0, 20'h0, 1'b0);
      checkOutput("rmid_status", 32'(status), 'h002);
      idle(100);
      checkOutput("rmid_quiet", 32'(tx), 1);

      // Random bursts that keep the FIFO partly full and wrap the pointers.
      sent = 0;
      while (sent < 20) begin
         for (int b = $urandom_range(1, 3); b > 0 && sent < 20; b--) begin
            applyStimulus(DATA_A, 20'($urandom_range(0, 255)), 1'b1);
            sent++;
         end
         for (int g = $urandom_range(40, 90); g > 0; g--) begin
            if ($urandom_range(0, 15) == 0) applyStimulus(20'h0100, 20'($urandom_range(0, 255)), 1'b1);
            else if ($urandom_range(0, 15) == 0) applyStimulus(STATUS_A, 20'h0, 1'b0);
            else applyStimulus(20'h0, 20'h0, 1'b0);
         end
      end
      idle(900);
      checkOutput("wrap_drained", 32'(busy), 0);

      modelOn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
